// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding,
// mode bit meanings and the select-width to output-width helper.
package scan_dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int unsigned onehot_w(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Purely combinational SEL_W-to-2**SEL_W one-hot decoder.
module onehot_dec
    import scan_dec_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0]           i_idx,
    output logic [onehot_w(SEL_W)-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with DIRECT (valid/ready select) and SCAN
// (auto-cycling with dwell) modes. SCAN_DEC_ACTIVE_LOW_EN inverts the dec_out pin.
module scan_decoder
    import scan_dec_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       mode,
    input  logic                       sel_valid,
    output logic                       sel_ready,
    input  logic [SEL_W-1:0]           sel,
    output logic [onehot_w(SEL_W)-1:0] dec_out,
    output logic [SEL_W-1:0]           cur_idx,
    output logic                       wrap
);

    localparam int unsigned OUT_W   = onehot_w(SEL_W);
    localparam int unsigned DWELL_W = $clog2(DWELL + 1);

    state_t               r_state;
    logic [SEL_W-1:0]     r_idx;
    logic [DWELL_W-1:0]   r_dwell;
    logic [OUT_W-1:0]     r_dec;
    logic                 r_wrap;

    state_t               w_state_nxt;
    logic [SEL_W-1:0]     w_idx_nxt;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic                 w_wrap_nxt;
    logic                 w_load;
    logic                 w_blank;
    logic [OUT_W-1:0]     w_onehot;

    assign sel_ready = en && (mode == MODE_DIRECT) && !rst;

    // Decoder sees the next index so dec_out and cur_idx update on the same edge.
    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .i_idx    (w_idx_nxt),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_wrap_nxt  = 1'b0;
        w_load      = 1'b0;
        w_blank     = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_blank     = 1'b1;
        end else if (mode == MODE_SCAN) begin
            w_state_nxt = SCAN;
            w_load      = 1'b1;
            if (r_state != SCAN) begin
                w_idx_nxt   = '0;
                w_dwell_nxt = '0;
            end else if (r_dwell == DWELL_W'(DWELL - 1)) begin
                w_dwell_nxt = '0;
                w_idx_nxt   = r_idx + 1'b1;
                w_wrap_nxt  = (r_idx == '1);
            end else begin
                w_dwell_nxt = r_dwell + 1'b1;
            end
        end else begin
            w_state_nxt = DIRECT;
            if (sel_valid && sel_ready) begin
                w_idx_nxt = sel;
                w_load    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dwell <= '0;
            r_dec   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_wrap  <= w_wrap_nxt;
            if (w_blank)
                r_dec <= '0;
            else if (w_load)
                r_dec <= w_onehot;
        end
    end

    assign cur_idx = r_idx;
    assign wrap    = r_wrap;

`ifdef SCAN_DEC_ACTIVE_LOW_EN
    assign dec_out = ~r_dec;
`else
    assign dec_out = r_dec;
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Table-driven bench for scan_decoder (DWELL=4 instance) plus a DWELL=1 wrap
// sequence; expected values travel through a scoreboard queue.
module tb_scan_decoder;

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic       vld;
        logic [2:0] sel;
        logic [7:0] dec;
        logic [2:0] idx;
        logic       wrap;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, en4 = 1'b0, mode4 = 1'b0, vld4 = 1'b0;
    logic [2:0] sel4 = '0;
    logic       rdy4, wrap4;
    logic [7:0] dec4;
    logic [2:0] idx4;

    logic       rst1 = 1'b1, en1 = 1'b0, mode1 = 1'b0, vld1 = 1'b0;
    logic [2:0] sel1 = '0;
    logic       rdy1, wrap1;
    logic [7:0] dec1;
    logic [2:0] idx1;

    scan_decoder #(.SEL_W(3), .DWELL(4)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .sel_valid(vld4),
        .sel_ready(rdy4), .sel(sel4), .dec_out(dec4), .cur_idx(idx4), .wrap(wrap4)
    );

    scan_decoder #(.SEL_W(3), .DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel_valid(vld1),
        .sel_ready(rdy1), .sel(sel1), .dec_out(dec1), .cur_idx(idx1), .wrap(wrap1)
    );

    vec_t tbl4[$];
    vec_t tbl1[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [7:0] pin(input logic [7:0] x);
`ifdef SCAN_DEC_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(input int r, input int e, input int m, input int v, input int s,
                                input int d, input int i, input int w, input int rd);
        vec_t t;
        t.rst = 1'(r); t.en = 1'(e); t.mode = 1'(m); t.vld = 1'(v); t.sel = 3'(s);
        t.dec = 8'(d); t.idx = 3'(i); t.wrap = 1'(w); t.rdy = 1'(rd);
        return t;
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] want);
        if (act !== want) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, k, act, want);
        end
    endtask

    task automatic run(input vec_t v, input bit use1, input int k);
        vec_t e;
        @(negedge clk);
        if (use1) begin
            rst1 = v.rst; en1 = v.en; mode1 = v.mode; vld1 = v.vld; sel1 = v.sel;
        end else begin
            rst4 = v.rst; en4 = v.en; mode4 = v.mode; vld4 = v.vld; sel4 = v.sel;
        end
        exp_q.push_back(v);
        n_vec++;
        #1;
        chk("sel_ready", k, 8'(use1 ? rdy1 : rdy4), 8'(v.rdy));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("dec_out", k, use1 ? dec1 : dec4, pin(e.dec));
        chk("cur_idx", k, 8'(use1 ? idx1 : idx4), 8'(e.idx));
        chk("wrap",    k, 8'(use1 ? wrap1 : wrap4), 8'(e.wrap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with en=1, mode=1, then scan: 01 for four cycles, then 02.
        tbl4.push_back(mk(1,1,1,0,0, 'h00,0,0,0));
        tbl4.push_back(mk(1,1,1,0,0, 'h00,0,0,0));
        tbl4.push_back(mk(0,1,1,0,0, 'h01,0,0,0));
        for (int n = 1; n <= 4; n++) tbl4.push_back(mk(0,1,1,0,0, 1 << (n/4), n/4, 0, 0));
        // DIRECT handshake sel=5, then hold with valid low.
        tbl4.push_back(mk(0,1,0,1,5, 'h20,5,0,1));
        tbl4.push_back(mk(0,1,0,0,2, 'h20,5,0,1));
        tbl4.push_back(mk(0,1,0,0,2, 'h20,5,0,1));
        // Scan to index 6, switch to DIRECT: hold 40 until the sel=2 handshake.
        tbl4.push_back(mk(0,1,1,0,0, 'h01,0,0,0));
        for (int n = 1; n <= 24; n++) tbl4.push_back(mk(0,1,1,0,0, 1 << (n/4), n/4, 0, 0));
        tbl4.push_back(mk(0,1,0,0,0, 'h40,6,0,1));
        tbl4.push_back(mk(0,1,0,0,0, 'h40,6,0,1));
        tbl4.push_back(mk(0,1,0,1,2, 'h04,2,0,1));
        // mode=1 with sel_valid=1: no accept, scan restarts at 01.
        tbl4.push_back(mk(0,1,1,1,2, 'h01,0,0,0));
        for (int n = 1; n <= 12; n++) tbl4.push_back(mk(0,1,1,0,0, 1 << (n/4), n/4, 0, 0));
        // en=0 at index 3: blank, index holds; re-enable in DIRECT stays blank until handshake.
        tbl4.push_back(mk(0,0,1,0,0, 'h00,3,0,0));
        tbl4.push_back(mk(0,0,0,1,4, 'h00,3,0,0));
        tbl4.push_back(mk(0,1,0,0,0, 'h00,3,0,1));
        tbl4.push_back(mk(0,1,0,1,7, 'h80,7,0,1));
        // Reset pulse mid-scan, then a full scan lap with wrap at DWELL=4.
        tbl4.push_back(mk(0,1,1,0,0, 'h01,0,0,0));
        for (int n = 1; n <= 6; n++) tbl4.push_back(mk(0,1,1,0,0, 1 << (n/4), n/4, 0, 0));
        tbl4.push_back(mk(1,1,1,0,0, 'h00,0,0,0));
        tbl4.push_back(mk(0,1,1,0,0, 'h01,0,0,0));
        for (int n = 1; n <= 33; n++)
            tbl4.push_back(mk(0,1,1,0,0, 1 << ((n/4)%8), (n/4)%8, (n == 32) ? 1 : 0, 0));

        // DWELL=1: walk 01..80 then 01 with a single wrap pulse.
        tbl1.push_back(mk(1,1,1,0,0, 'h00,0,0,0));
        tbl1.push_back(mk(0,1,1,0,0, 'h01,0,0,0));
        for (int k = 1; k <= 10; k++)
            tbl1.push_back(mk(0,1,1,1,k%8, 1 << (k%8), k%8, (k == 8) ? 1 : 0, 0));
        tbl1.push_back(mk(0,0,1,0,0, 'h00,2,0,0));

        for (int i = 0; i < tbl4.size(); i++) run(tbl4[i], 1'b0, i);
        for (int i = 0; i < tbl1.size(); i++) run(tbl1[i], 1'b1, 1000 + i);

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
